// File: rtl/tick_gen_multi_pkg.sv
// Shared definitions for the multi-channel tick generator: channel states,
// mode encodings and the width of a per-channel period select.
package tick_gen_multi_pkg;

  localparam int SEL_W = 2;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tick_gen_multi_ch.sv
// One tick channel: IDLE/RUN FSM, down-counter with period table lookup,
// registered o_valid pulse and o_busy (= RUN).
module tick_gen_multi_ch
  import tick_gen_multi_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int unsigned PERIOD0 = 100_000_000,
  parameter int unsigned PERIOD1 = 50_000_000,
  parameter int unsigned PERIOD2 = 25_000_000,
  parameter int unsigned PERIOD3 = 10_000_000
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_mode,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_valid,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] RLD0 = CNT_W'(PERIOD0 - 1);
  localparam logic [CNT_W-1:0] RLD1 = CNT_W'(PERIOD1 - 1);
  localparam logic [CNT_W-1:0] RLD2 = CNT_W'(PERIOD2 - 1);
  localparam logic [CNT_W-1:0] RLD3 = CNT_W'(PERIOD3 - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_reload;
  logic             r_valid;
  logic             w_valid_nxt;

  // Reload value follows i_sel live; it is only consumed on start or at a
  // period boundary, which is what makes a period change glitch-free.
  always_comb begin
    w_reload = RLD0;
    case (i_sel)
      2'b00:   w_reload = RLD0;
      2'b01:   w_reload = RLD1;
      2'b10:   w_reload = RLD2;
      default: w_reload = RLD3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (i_start) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = w_reload;
    end else if (r_state == ST_RUN && i_enable) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
        w_valid_nxt = 1'b1;
        if (i_mode == MODE_ONESHOT) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_reload;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_busy  = (r_state == ST_RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: slices i_sel per channel, fans
// i_sync out as a start to every channel, and rejects bad period tables.
module tick_gen_multi
  import tick_gen_multi_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned PERIOD0 = 100_000_000,
  parameter int unsigned PERIOD1 = 50_000_000,
  parameter int unsigned PERIOD2 = 25_000_000,
  parameter int unsigned PERIOD3 = 10_000_000
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_enable,
  input  logic [SEL_W*NUM_CH-1:0] i_sel,
  input  logic [NUM_CH-1:0]       i_mode,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH-1:0]       i_stop,
  input  logic                    i_sync,
  output logic [NUM_CH-1:0]       o_valid,
  output logic [NUM_CH-1:0]       o_busy
);

  // A counter of CNT_W bits reloads with P-1, so P may reach 2^CNT_W.
  localparam logic [63:0] P_LIMIT = 64'd1 << CNT_W;

  if (PERIOD0 == 0 || PERIOD1 == 0 || PERIOD2 == 0 || PERIOD3 == 0) begin : g_bad_zero
    $error("tick_gen_multi: every PERIODn must be >= 1");
  end

  if (64'(PERIOD0) > P_LIMIT || 64'(PERIOD1) > P_LIMIT ||
      64'(PERIOD2) > P_LIMIT || 64'(PERIOD3) > P_LIMIT) begin : g_bad_width
    $error("tick_gen_multi: a PERIODn does not fit in CNT_W bits");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [SEL_W-1:0] w_sel;
    logic             w_start;

    assign w_sel   = i_sel[SEL_W*k +: SEL_W];
    assign w_start = i_start[k] | i_sync;

    tick_gen_multi_ch #(
      .CNT_W   (CNT_W),
      .PERIOD0 (PERIOD0),
      .PERIOD1 (PERIOD1),
      .PERIOD2 (PERIOD2),
      .PERIOD3 (PERIOD3)
    ) u_ch (
      .clk      (clk),
      .i_rst_n  (i_rst_n),
      .i_enable (i_enable[k]),
      .i_sel    (w_sel),
      .i_mode   (i_mode[k]),
      .i_start  (w_start),
      .i_stop   (i_stop[k]),
      .o_valid  (o_valid[k]),
      .o_busy   (o_busy[k])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: per-cycle pulse/busy masks of each
// scenario are compared with hand-computed cycle numbers.
module tb_tick_gen_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                  clk;
  logic                  i_rst_n;
  logic [NUM_CH-1:0]     i_enable;
  logic [2*NUM_CH-1:0]   i_sel;
  logic [NUM_CH-1:0]     i_mode;
  logic [NUM_CH-1:0]     i_start;
  logic [NUM_CH-1:0]     i_stop;
  logic                  i_sync;
  logic [NUM_CH-1:0]     o_valid;
  logic [NUM_CH-1:0]     o_busy;

  int total = 0;
  int bad   = 0;

  tick_gen_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PERIOD0 (10),
    .PERIOD1 (5),
    .PERIOD2 (3),
    .PERIOD3 (1)
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_sel    (i_sel),
    .i_mode   (i_mode),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_sync   (i_sync),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c of a scenario is the interval after the c-th rising edge counted
  // from the edge following apply_reset; inputs and samples happen at negedges.
  task automatic apply_reset();
    i_rst_n  = 1'b0;
    i_enable = '0;
    i_sel    = '0;
    i_mode   = '0;
    i_start  = '0;
    i_stop   = '0;
    i_sync   = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_enable = '1;
    i_sel    = '1;
    i_mode   = '0;
    i_start  = '1;
    i_stop   = '0;
    i_sync   = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (o_valid !== 2'b00) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=00", o_valid);
    end
    total++;
    if (o_busy !== 2'b00) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=00", o_busy);
    end
  endtask

  task automatic test_cont();
    logic [63:0] m0, m1, b0, e0, eb;
    m0 = '0; m1 = '0; b0 = '0; e0 = '0; eb = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      m0[c]   = o_valid[0];
      m1[c]   = o_valid[1];
      b0[c]   = o_busy[0];
      i_start = (c == 0) ? 2'b01 : 2'b00;
    end
    e0[11] = 1'b1; e0[21] = 1'b1; e0[31] = 1'b1;
    for (int c = 1; c < 40; c++) eb[c] = 1'b1;
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL cont_valid0 got=%h exp=%h", m0, e0);
    end
    total++;
    if (b0 !== eb) begin
      bad++;
      $display("FAIL cont_busy0 got=%h exp=%h", b0, eb);
    end
    total++;
    if (m1 !== 64'd0) begin
      bad++;
      $display("FAIL cont_idle_ch1 got=%h exp=0", m1);
    end
  endtask

  task automatic test_oneshot();
    logic [63:0] m0, b0, e0, eb;
    m0 = '0; b0 = '0; e0 = '0; eb = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0001;
    i_mode   = 2'b01;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      m0[c]   = o_valid[0];
      b0[c]   = o_busy[0];
      i_start = (c == 0) ? 2'b01 : 2'b00;
    end
    e0[6] = 1'b1;
    for (int c = 1; c < 6; c++) eb[c] = 1'b1;
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL oneshot_valid got=%h exp=%h", m0, e0);
    end
    total++;
    if (b0 !== eb) begin
      bad++;
      $display("FAIL oneshot_busy got=%h exp=%h", b0, eb);
    end
  endtask

  task automatic test_sel_change();
    logic [63:0] m0, e0;
    m0 = '0; e0 = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m0[c]      = o_valid[0];
      i_start    = (c == 0) ? 2'b01 : 2'b00;
      i_sel[1:0] = (c >= 4) ? 2'b10 : 2'b00;
    end
    e0[11] = 1'b1; e0[14] = 1'b1; e0[17] = 1'b1;
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL sel_change_valid got=%h exp=%h", m0, e0);
    end
  endtask

  task automatic test_pause_stop();
    logic [63:0] m0, b0, e0, eb;
    m0 = '0; b0 = '0; e0 = '0; eb = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      m0[c]       = o_valid[0];
      b0[c]       = o_busy[0];
      i_start     = (c == 0 || c == 18) ? 2'b01 : 2'b00;
      i_stop      = (c == 18) ? 2'b01 : 2'b00;
      i_enable[0] = !(c >= 3 && c <= 5);
    end
    e0[9] = 1'b1; e0[14] = 1'b1;
    for (int c = 1; c < 19; c++) eb[c] = 1'b1;
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL pause_stop_valid got=%h exp=%h", m0, e0);
    end
    total++;
    if (b0 !== eb) begin
      bad++;
      $display("FAIL pause_stop_busy got=%h exp=%h", b0, eb);
    end
  endtask

  task automatic test_sync();
    logic [63:0] m0, m1, b1, e0, e1, eb;
    m0 = '0; m1 = '0; b1 = '0; e0 = '0; e1 = '0; eb = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0100;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      m0[c]   = o_valid[0];
      m1[c]   = o_valid[1];
      b1[c]   = o_busy[1];
      i_start = (c == 0) ? 2'b01 : ((c == 2) ? 2'b10 : 2'b00);
      i_sync  = (c == 20);
    end
    e0[11] = 1'b1; e0[31] = 1'b1;
    e1[8] = 1'b1; e1[13] = 1'b1; e1[18] = 1'b1;
    e1[26] = 1'b1; e1[31] = 1'b1; e1[36] = 1'b1;
    for (int c = 3; c < 38; c++) eb[c] = 1'b1;
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL sync_valid0 got=%h exp=%h", m0, e0);
    end
    total++;
    if (m1 !== e1) begin
      bad++;
      $display("FAIL sync_valid1 got=%h exp=%h", m1, e1);
    end
    total++;
    if (b1 !== eb) begin
      bad++;
      $display("FAIL sync_busy1 got=%h exp=%h", b1, eb);
    end
  endtask

  task automatic test_midreset_p1();
    logic [63:0] m0, b0, e0, eb;
    m0 = '0; b0 = '0; e0 = '0; eb = '0;
    apply_reset();
    i_enable = 2'b11;
    i_sel    = 4'b0000;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      m0[c] = o_valid[0];
      b0[c] = o_busy[0];
      if (c == 7) begin
        total++;
        if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
          bad++;
          $display("FAIL midreset_clear got=%b%b exp=00", o_valid[0], o_busy[0]);
        end
      end
      i_start    = (c == 0 || c == 6 || c == 7 || c == 25) ? 2'b01 : 2'b00;
      i_rst_n    = (c != 6);
      i_sel[1:0] = (c >= 25) ? 2'b11 : 2'b00;
    end
    e0[18] = 1'b1;
    for (int c = 27; c < 32; c++) e0[c] = 1'b1;
    for (int c = 1; c < 32; c++) eb[c] = (c != 7);
    total++;
    if (m0 !== e0) begin
      bad++;
      $display("FAIL midreset_valid got=%h exp=%h", m0, e0);
    end
    total++;
    if (b0 !== eb) begin
      bad++;
      $display("FAIL midreset_busy got=%h exp=%h", b0, eb);
    end
  endtask

  initial begin
    test_reset();
    test_cont();
    test_oneshot();
    test_sel_change();
    test_pause_stop();
    test_sync();
    test_midreset_p1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
